// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler that frames requester messages as header+payload bytes into the UART TX FIFO.
// Optional checksum byte (header ^ payload) is enabled with `define UART_TX_CHECKSUM_EN.
module uart_tx_scheduler #(
  parameter int          N_REQ  = 4,
  parameter logic [3:0]  TAG_HI = 4'hA
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   grant,
  input  logic               tx_full,
  output logic               wr_uart,
  output logic [7:0]         w_data,
  output logic               busy
);

`ifdef UART_TX_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, HDR, PAY, CHK} state_t;
  localparam state_t FINAL_ST = CHK;
`else
  typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;
  localparam state_t FINAL_ST = PAY;
`endif

  state_t      state;
  logic [1:0]  idx;
  logic [1:0]  last;
  logic [7:0]  payload;
`ifdef UART_TX_CHECKSUM_EN
  logic [7:0]  hdr;
`endif

  logic        sel_vld;
  logic [1:0]  sel;
  logic [7:0]  sel_data;

  function automatic int unsigned rot(input int unsigned base, input int unsigned k);
    return (base + 1 + k) % N_REQ;
  endfunction

  // First set request searching upward from the slot after the last grant.
  always_comb begin
    sel_vld = 1'b0;
    sel     = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!sel_vld && req[rot(32'(last), k)]) begin
        sel_vld = 1'b1;
        sel     = 2'(rot(32'(last), k));
      end
    end
    sel_data = req_data[8*sel +: 8];
  end

  assign busy    = (state != IDLE);
  assign wr_uart = busy && !tx_full;

  always_comb begin
    grant = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (wr_uart && state == FINAL_ST && idx == 2'(i)) grant[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      idx     <= '0;
      last    <= 2'(N_REQ - 1);
      payload <= '0;
      w_data  <= '0;
`ifdef UART_TX_CHECKSUM_EN
      hdr     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (sel_vld) begin
            idx     <= sel;
            last    <= sel;
            payload <= sel_data;
            w_data  <= {TAG_HI, 2'b00, sel};
`ifdef UART_TX_CHECKSUM_EN
            hdr     <= {TAG_HI, 2'b00, sel};
`endif
            state   <= HDR;
          end
        end
        HDR: begin
          if (!tx_full) begin
            w_data <= payload;
            state  <= PAY;
          end
        end
        PAY: begin
          if (!tx_full) begin
`ifdef UART_TX_CHECKSUM_EN
            w_data <= hdr ^ payload;
            state  <= CHK;
`else
            state  <= IDLE;
`endif
          end
        end
`ifdef UART_TX_CHECKSUM_EN
        CHK: begin
          if (!tx_full) state <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed and randomized bench for uart_tx_scheduler against a message-queue reference model.
module tb_uart_tx_scheduler;
  localparam int N = 4;
`ifdef UART_TX_CHECKSUM_EN
  localparam int MSG_LEN = 3;
`else
  localparam int MSG_LEN = 2;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           tx_full;
  logic [N-1:0]   req;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   grant;
  logic           wr_uart;
  logic [7:0]     w_data;
  logic           busy;

  always #5 clk = ~clk;

  uart_tx_scheduler #(.N_REQ(N), .TAG_HI(4'hA)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .grant(grant),
    .tx_full(tx_full), .wr_uart(wr_uart), .w_data(w_data), .busy(busy)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]   q[$];
  int unsigned  m_last = N - 1;
  int unsigned  m_idx = 0;
  logic [N-1:0] granted = '0;
  logic [7:0]   wlog[$];
  logic [N-1:0] glog[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare one cycle against the model, then advance to the next negedge.
  task automatic cycle();
    logic [N-1:0] eg;
    logic [7:0]   hb, pb;
    int unsigned  p;
    #1;
    if (wr_uart === 1'b1) begin
      wlog.push_back(w_data);
      glog.push_back(grant);
    end
    if (!rst) begin
      check("rst_wr", 32'(wr_uart), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_grant", 32'(grant), 0);
      check("rst_wdata", 32'(w_data), 0);
      q.delete();
      m_last  = N - 1;
      granted = '0;
    end else if (q.size() == 0) begin
      check("idle_busy", 32'(busy), 0);
      check("idle_wr", 32'(wr_uart), 0);
      check("idle_grant", 32'(grant), 0);
      granted = '0;
      for (int k = 0; k < N; k++) begin
        p = (m_last + 1 + k) % N;
        if (req[p]) begin
          m_idx  = p;
          m_last = p;
          hb = 8'hA0 | 8'(p);
          pb = req_data[8*p +: 8];
          q.push_back(hb);
          q.push_back(pb);
`ifdef UART_TX_CHECKSUM_EN
          q.push_back(hb ^ pb);
`endif
          break;
        end
      end
    end else begin
      eg = '0;
      check("msg_busy", 32'(busy), 1);
      check("msg_wr", 32'(wr_uart), 32'(!tx_full));
      check("msg_wdata", 32'(w_data), 32'(q[0]));
      if (!tx_full) begin
        if (q.size() == 1) eg[m_idx] = 1'b1;
        void'(q.pop_front());
      end
      check("msg_grant", 32'(grant), 32'(eg));
      granted = eg;
    end
    @(negedge clk);
    req = req & ~granted;
  endtask

  task automatic drain(input int lim);
    int n = 0;
    while ((req != 0 || q.size() != 0) && n < lim) begin
      cycle();
      n++;
    end
    check("drain_req", 32'(req), 0);
    check("drain_q", 32'(q.size()), 0);
  endtask

  initial begin
    logic [N-1:0] oh;
    rst = 1'b0; req = '0; req_data = '0; tx_full = 1'b0;
    @(negedge clk);
    cycle();
    cycle();
    rst = 1'b1;

    // All four requesting from reset: rotate 0,1,2,3
    wlog.delete(); glog.delete();
    req_data = {$urandom, 1'b0} ^ 33'($urandom);
    req = '1;
    drain(60);
    check("all_nwrites", 32'(wlog.size()), 32'(4 * MSG_LEN));
    for (int i = 0; i < 4; i++) begin
      oh = '0; oh[i] = 1'b1;
      if (wlog.size() == 4 * MSG_LEN) begin
        check("all_hdr", 32'(wlog[i*MSG_LEN]), 32'(8'hA0 + i));
        check("all_grant", 32'(glog[i*MSG_LEN + MSG_LEN - 1]), 32'(oh));
      end
    end
    cycle();

    // Single request on requester 2
    wlog.delete(); glog.delete();
    req_data[23:16] = 8'h37;
    req = 4'b0100;
    drain(20);
    check("single_n", 32'(wlog.size()), 32'(MSG_LEN));
    check("single_hdr", 32'(wlog[0]), 32'h A2);
    check("single_pay", 32'(wlog[1]), 32'h37);
    check("single_grant", 32'(glog[MSG_LEN-1]), 32'b0100);
    cycle();
    check("single_busy_fall", 32'(busy), 0);

    // Backpressure on requester 1
    wlog.delete(); glog.delete();
    req_data[15:8] = 8'h55;
    req = 4'b0010;
    cycle();
    tx_full = 1'b1;
    repeat (5) cycle();
    check("bp_nowrite", 32'(wlog.size()), 0);
    tx_full = 1'b0;
    drain(20);
    check("bp_n", 32'(wlog.size()), 32'(MSG_LEN));
    check("bp_hdr", 32'(wlog[0]), 32'hA1);
    check("bp_pay", 32'(wlog[1]), 32'h55);

    // Payload changed after selection
    wlog.delete(); glog.delete();
    req_data[7:0] = 8'h11;
    req = 4'b0001;
    cycle();
    req_data[7:0] = 8'h99;
    drain(20);
    check("latch_pay", 32'(wlog[1]), 32'h11);

    // Reset mid-message on requester 1, then pointer back at 3
    wlog.delete(); glog.delete();
    req_data[15:8] = 8'h5A;
    req = 4'b0010;
    cycle();
    cycle();
    tx_full = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    check("rst_mid_n", 32'(wlog.size()), 1);
    check("rst_mid_nogrant", 32'(glog[0]), 0);
    rst = 1'b1;
    tx_full = 1'b0;
    req_data[31:24] = 8'hC3;
    req = 4'b1010;
    wlog.delete(); glog.delete();
    drain(30);
    check("rst_ptr_first", 32'(wlog[0]), 32'hA1);
    check("rst_ptr_second", 32'(wlog[MSG_LEN]), 32'hA3);

`ifdef UART_TX_CHECKSUM_EN
    wlog.delete(); glog.delete();
    req_data[15:8] = 8'h0F;
    req = 4'b0010;
    drain(20);
    check("chk_b0", 32'(wlog[0]), 32'hA1);
    check("chk_b1", 32'(wlog[1]), 32'h0F);
    check("chk_b2", 32'(wlog[2]), 32'hAE);
    check("chk_grant", 32'(glog[2]), 32'b0010);
`endif

    // Randomized traffic with random backpressure
    repeat (400) begin
      tx_full = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom_range(0, 2) == 0) begin
          req_data[8*i +: 8] = 8'($urandom);
          req[i] = 1'b1;
        end
      end
      cycle();
    end
    tx_full = 1'b0;
    drain(100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
